lampfpu_fract_sqrt_rsqrt: RTL and testbench

Parametrised iterative fraction square-root and inverse-square-root unit for the lampFPU datapath. Takes the significand (hidden bit plus fraction) with an odd-exponent flag. Produces either sqrt or 1/sqrt as an unsigned 1.(OUT_W-1) fixed-point value plus a sticky bit for the rounding stage. Uses a restoring digit recurrence, one bit per cycle, with a start/ready/valid handshake and synchronous flush.

---
 rtl/lampFPU_pkg.sv | 13 +
 rtl/lampfpu_fract_sqrt_rsqrt_if.sv | 29 ++
 rtl/lampfpu_fract_div.sv | 73 +++++++
 rtl/lampfpu_fract_sqrt_rsqrt.sv | 174 +++++++++++++++++
 tb/tb_lampfpu_fract_sqrt_rsqrt.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lampFPU_pkg.sv
// Shared constants and types for the lampFPU fraction sqrt / inverse-sqrt unit.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_F_DW = 7;

  typedef enum logic [1:0] {
    IDLE,
    SQRT,
    DIV,
    DONE
  } lampfpu_sqrt_state_t;

endpackage

// File: rtl/lampfpu_fract_sqrt_rsqrt_if.sv
// Start/ready/valid handshake bundle between the lampFPU datapath and the sqrt/rsqrt unit.
interface lampfpu_fract_sqrt_rsqrt_if #(
  parameter int F_DW  = lampFPU_pkg::LAMP_FLOAT_F_DW,
  parameter int OUT_W = 2 * (1 + lampFPU_pkg::LAMP_FLOAT_F_DW)
);

  logic             flush_i;
  logic             start_i;
  logic             doSqrt_i;
  logic             doInvSqrt_i;
  logic [F_DW:0]    s_i;
  logic             oddExp_i;
  logic             ready_o;
  logic             valid_o;
  logic [OUT_W-1:0] result_o;
  logic             sticky_o;
  logic             divByZero_o;

  modport master (
    output flush_i, start_i, doSqrt_i, doInvSqrt_i, s_i, oddExp_i,
    input  ready_o, valid_o, result_o, sticky_o, divByZero_o
  );

  modport slave (
    input  flush_i, start_i, doSqrt_i, doInvSqrt_i, s_i, oddExp_i,
    output ready_o, valid_o, result_o, sticky_o, divByZero_o
  );

endinterface

// File: rtl/lampfpu_fract_div.sv
// Restoring W-bit divider: one quotient bit per step, done after W steps.
// The dividend's upper half must be smaller than the divisor for the quotient to fit.
module lampfpu_fract_div #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [2*W-1:0] dividend_i,
  input  logic [W-1:0]   divisor_i,
  output logic [W-1:0]   quot_o,
  output logic           rem_nz_o,
  output logic           done_o
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(W);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W:0] sh;
  logic [W:0] diff;
  logic       ge;

  // The quotient register starts out holding the dividend's low half and shifts it into the remainder.
  always_comb begin
    sh   = {rem_q, quot_q[W-1]};
    diff = sh - {1'b0, divisor_q};
    ge   = (sh >= {1'b0, divisor_q});
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      rem_d     = dividend_i[2*W-1:W];
      quot_d    = dividend_i[W-1:0];
      divisor_d = divisor_i;
      cnt_d     = '0;
    end else if (step_i && (cnt_q != CNT_END)) begin
      rem_d  = ge ? diff[W-1:0] : sh[W-1:0];
      quot_d = {quot_q[W-2:0], ge};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
    end
  end

  assign quot_o   = quot_q;
  assign rem_nz_o = |rem_q;
  assign done_o   = (cnt_q == CNT_END);

endmodule

// File: rtl/lampfpu_fract_sqrt_rsqrt.sv
// Iterative fraction sqrt / inverse-sqrt: restoring sqrt recurrence, then an optional
// restoring division of 2^(2*(OUT_W-1)) by the root, one bit per cycle.
module lampfpu_fract_sqrt_rsqrt
  import lampFPU_pkg::*;
#(
  parameter int F_DW  = LAMP_FLOAT_F_DW,
  parameter int OUT_W = 2 * (1 + LAMP_FLOAT_F_DW)
) (
  input logic                       clk,
  input logic                       rst,
  lampfpu_fract_sqrt_rsqrt_if.slave io
);

  localparam int N_W   = 2 * OUT_W;
  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam int SHAMT = 2 * (OUT_W - 1) - F_DW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OUT_W);
  localparam logic [OUT_W-1:0] SAT_LIM  = {2'b01, {(OUT_W-2){1'b0}}};
  localparam logic [N_W-1:0]   DIV_NUM  = {2'b01, {(N_W-2){1'b0}}};

  lampfpu_sqrt_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                inv_q, inv_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [OUT_W+1:0]    r_q, r_d;
  logic [OUT_W-1:0]    q_q, q_d;
  logic [OUT_W-1:0]    result_q, result_d;
  logic                sticky_q, sticky_d;
  logic                dbz_q, dbz_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;

  logic [N_W-1:0]   s_ext, n_load, n_step;
  logic [OUT_W+1:0] r_sh, trial, r_step;
  logic             r_ge;
  logic [OUT_W-1:0] q_step;

  logic             div_load, div_step, div_done, div_rem_nz;
  logic [OUT_W-1:0] div_quot;

  // One root bit per step: bring down two radicand bits and try subtracting 4q+1.
  // The remainder never exceeds 2q, so its top two bits are zero before each shift.
  always_comb begin
    s_ext  = N_W'(io.s_i);
    n_load = io.oddExp_i ? (s_ext << (SHAMT + 1)) : (s_ext << SHAMT);
    n_step = n_q << 2;
    r_sh   = {r_q[OUT_W-1:0], n_q[N_W-1 -: 2]};
    trial  = {q_q, 2'b01};
    r_ge   = (r_sh >= trial);
    r_step = r_ge ? (r_sh - trial) : r_sh;
    q_step = {q_q[OUT_W-2:0], r_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    n_d      = n_q;
    r_d      = r_q;
    q_d      = q_q;
    result_d = result_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    div_load = 1'b0;
    div_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.start_i && (io.doSqrt_i || io.doInvSqrt_i)) begin
          state_d = SQRT;
          inv_d   = io.doInvSqrt_i;
          n_d     = n_load;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
        end
      end
      SQRT: begin
        if (cnt_q != CNT_END) begin
          n_d   = n_step;
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q + CNT_W'(1);
          // The divider is loaded with the final root as it is produced, saving a cycle.
          if (inv_q && (cnt_q == CNT_LAST)) begin
            state_d  = DIV;
            div_load = 1'b1;
          end
        end else begin
          state_d  = DONE;
          result_d = q_q;
          sticky_d = |r_q;
          dbz_d    = 1'b0;
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (div_done) begin
          state_d = DONE;
          if (q_q <= SAT_LIM) begin
            result_d = '1;
            sticky_d = 1'b1;
          end else begin
            result_d = div_quot;
            sticky_d = (|r_q) | div_rem_nz;
          end
          dbz_d = (q_q == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (io.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
      sticky_d = sticky_q;
      dbz_d    = dbz_q;
    end

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
      n_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      result_q <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      n_q      <= n_d;
      r_q      <= r_d;
      q_q      <= q_d;
      result_q <= result_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  lampfpu_fract_div #(
    .W(OUT_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (DIV_NUM),
    .divisor_i  (q_step),
    .quot_o     (div_quot),
    .rem_nz_o   (div_rem_nz),
    .done_o     (div_done)
  );

  assign io.ready_o     = ready_q;
  assign io.valid_o     = valid_q;
  assign io.result_o    = result_q;
  assign io.sticky_o    = sticky_q;
  assign io.divByZero_o = dbz_q;

endmodule

// File: tb/tb_lampfpu_fract_sqrt_rsqrt.sv
// Scoreboard bench for the sqrt / inverse-sqrt unit: directed cases with fixed expectations,
// randomized operands checked against an arithmetic reference model.
module tb_lampfpu_fract_sqrt_rsqrt;

  localparam int F_DW  = 7;
  localparam int OUT_W = 16;

  typedef struct {
    logic [OUT_W-1:0] res;
    logic             st;
    logic             dbz;
    int               lat;
    int               acc;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [OUT_W-1:0] last_res = '0;

  lampfpu_fract_sqrt_rsqrt_if io ();

  lampfpu_fract_sqrt_rsqrt dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [OUT_W-1:0] res, input logic st, input logic dbz,
                              input logic inv, input string tag);
    exp_t e;
    e.res = res; e.st = st; e.dbz = dbz; e.acc = 0; e.tag = tag;
    e.lat = inv ? 2 * OUT_W + 1 : OUT_W + 1;
    return e;
  endfunction

  // Reference: integer sqrt of the scaled radicand, then floor(2^(2*(OUT_W-1)) / root).
  function automatic exp_t model(input logic [F_DW:0] s, input logic odd, input logic inv,
                                 input string tag);
    longint n, q, rs, d, p, rd;
    exp_t   e;
    n  = longint'(s) << (2 * (OUT_W - 1) - F_DW + int'(odd));
    q  = longint'($sqrt(real'(n)));
    while (q * q > n) q--;
    while ((q + 1) * (q + 1) <= n) q++;
    rs = n - q * q;
    if (!inv) return mk(OUT_W'(q), rs != 0, 1'b0, 1'b0, tag);
    d = longint'(1) << (2 * (OUT_W - 1));
    if (q == 0) return mk('1, 1'b1, 1'b1, 1'b1, tag);
    p  = d / q;
    rd = d % q;
    if (p >= (longint'(1) << OUT_W)) e = mk('1, 1'b1, 1'b0, 1'b1, tag);
    else e = mk(OUT_W'(p), (rs != 0) || (rd != 0), 1'b0, 1'b1, tag);
    return e;
  endfunction

  task automatic run_op(input logic [F_DW:0] s, input logic odd, input logic do_sq,
                        input logic do_inv, input exp_t e);
    exp_t x;
    int   n;
    x = e;
    n = 0;
    while (io.ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({e.tag, "_ready_wait"}, {31'd0, io.ready_o}, 1);
    io.start_i     = 1'b1;
    io.doSqrt_i    = do_sq;
    io.doInvSqrt_i = do_inv;
    io.s_i         = s;
    io.oddExp_i    = odd;
    @(posedge clk); #1;
    io.start_i     = 1'b0;
    io.doSqrt_i    = 1'b0;
    io.doInvSqrt_i = 1'b0;
    x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || io.ready_o !== 1'b1) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (io.valid_o === 1'b1) begin
        check("valid_has_expectation", {31'd0, sb.size() > 0}, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({e.tag, "_result"}, {16'd0, io.result_o}, {16'd0, e.res});
          check({e.tag, "_sticky"}, {31'd0, io.sticky_o}, {31'd0, e.st});
          check({e.tag, "_divbyzero"}, {31'd0, io.divByZero_o}, {31'd0, e.dbz});
          check({e.tag, "_latency"}, cyc - e.acc, e.lat);
          check({e.tag, "_ready_low_on_valid"}, {31'd0, io.ready_o}, 0);
          last_res = e.res;
        end
      end
    end
  end

  initial begin : stimulus
    logic [F_DW:0] s;
    logic          odd;
    int            m;

    rst            = 1'b1;
    io.flush_i     = 1'b0;
    io.start_i     = 1'b0;
    io.doSqrt_i    = 1'b0;
    io.doInvSqrt_i = 1'b0;
    io.s_i         = '0;
    io.oddExp_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, io.ready_o}, 1);
    check("reset_valid", {31'd0, io.valid_o}, 0);
    check("reset_result", {16'd0, io.result_o}, 0);
    check("reset_sticky", {31'd0, io.sticky_o}, 0);
    check("reset_divbyzero", {31'd0, io.divByZero_o}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h40, 1'b0, 1'b1, 1'b0, mk(16'h5A82, 1'b1, 1'b0, 1'b0, "sqrt_half"));
    run_op(8'h40, 1'b0, 1'b0, 1'b1, mk(16'hB505, 1'b1, 1'b0, 1'b1, "rsqrt_half"));
    run_op(8'h80, 1'b0, 1'b1, 1'b0, mk(16'h8000, 1'b0, 1'b0, 1'b0, "sqrt_one"));
    run_op(8'h80, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b0, 1'b1, "rsqrt_one"));
    run_op(8'h80, 1'b1, 1'b1, 1'b0, mk(16'hB504, 1'b1, 1'b0, 1'b0, "sqrt_two"));
    run_op(8'h00, 1'b0, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b1, 1'b1, "rsqrt_zero"));
    run_op(8'h00, 1'b0, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0, "sqrt_zero"));
    run_op(8'h20, 1'b0, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b1, "rsqrt_sat_edge"));
    run_op(8'h40, 1'b0, 1'b1, 1'b1, mk(16'hB505, 1'b1, 1'b0, 1'b1, "both_modes_inv_wins"));
    drain("directed");

    for (int i = 0; i < 30; i++) begin
      s   = F_DW'($urandom_range(0, 255));
      odd = 1'($urandom_range(0, 1));
      m   = int'($urandom_range(0, 2));
      run_op(s, odd, m != 1, m != 0, model(s, odd, m != 0, $sformatf("rand%0d", i)));
    end
    drain("random");

    // Start with no mode selected must be ignored.
    io.start_i = 1'b1;
    io.s_i     = 8'h80;
    @(posedge clk); #1;
    io.start_i = 1'b0;
    check("nomode_ignored", {31'd0, io.ready_o}, 1);

    // Flush mid-sqrt: back to idle, held result untouched, no strobe.
    io.start_i  = 1'b1;
    io.doSqrt_i = 1'b1;
    io.s_i      = 8'hFF;
    @(posedge clk); #1;
    io.start_i  = 1'b0;
    io.doSqrt_i = 1'b0;
    check("flush_busy", {31'd0, io.ready_o}, 0);
    repeat (4) @(posedge clk);
    #1;
    io.flush_i = 1'b1;
    @(posedge clk); #1;
    io.flush_i = 1'b0;
    check("flush_ready", {31'd0, io.ready_o}, 1);
    check("flush_result_held", {16'd0, io.result_o}, {16'd0, last_res});
    repeat (40) @(posedge clk);
    #1;

    // Flush wins over a simultaneous start.
    io.flush_i  = 1'b1;
    io.start_i  = 1'b1;
    io.doSqrt_i = 1'b1;
    @(posedge clk); #1;
    io.flush_i  = 1'b0;
    io.start_i  = 1'b0;
    io.doSqrt_i = 1'b0;
    check("flush_beats_start", {31'd0, io.ready_o}, 1);
    repeat (25) @(posedge clk);
    #1;

    // Starts while busy are dropped: exactly one strobe for this operation.
    run_op(8'h80, 1'b0, 1'b1, 1'b0, mk(16'h8000, 1'b0, 1'b0, 1'b0, "busy_restart"));
    io.start_i     = 1'b1;
    io.doInvSqrt_i = 1'b1;
    io.s_i         = 8'h40;
    repeat (5) @(posedge clk);
    #1;
    io.start_i     = 1'b0;
    io.doInvSqrt_i = 1'b0;
    drain("busy_restart");
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of the division phase.
    run_op(8'h40, 1'b0, 1'b0, 1'b1, mk(16'hB505, 1'b1, 1'b0, 1'b1, "rst_victim"));
    repeat (25) @(posedge clk);
    #1;
    check("rst_pre_busy", {31'd0, io.ready_o}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check("rst_mid_ready", {31'd0, io.ready_o}, 1);
    check("rst_mid_valid", {31'd0, io.valid_o}, 0);
    check("rst_mid_result", {16'd0, io.result_o}, 0);
    check("rst_mid_sticky", {31'd0, io.sticky_o}, 0);
    check("rst_mid_divbyzero", {31'd0, io.divByZero_o}, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    run_op(8'h40, 1'b0, 1'b0, 1'b1, mk(16'hB505, 1'b1, 1'b0, 1'b1, "after_rst"));
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
